bp_be_loop_inference_scheduler: RTL and testbench
=================================================

# bp_be_loop_inference_scheduler

Controller that shares the single backend loop-inference unit among several striding-load requesters, e.g. stride-table entries. Round-robin grants one requester at a time. Pulses the unit's start, relays that requester's confirm, accepts the iteration estimate, and returns it tagged with the requester id. Sits in bp_be_checker between the stride detectors and the loop-inference datapath.

## Interface
- bp_params_p, e_bp_default_cfg: supplies vaddr_width_p
- num_req_p, 4: number of requesters (≥2); id width lg_req = clog2(num_req_p)
- output_range_p, 8: width of the iteration estimate
- timeout_cycles_p, 1024: unconfirmed-search abort limit; counter width clog2(timeout_cycles_p+1)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- req_v_i  in  num_req_p  per-requester discovery request, level
- req_pc_i  in  num_req_p*vaddr_width_p  striding-load PC per requester, slice i
- req_confirm_i  in  num_req_p  per-requester confirm pulse
- start_discovery_o  out  1  start pulse to inference unit
- confirm_discovery_o  out  1  confirm to inference unit
- striding_pc_o  out  vaddr_width_p  PC of the granted requester
- li_v_i  in  1  inference result valid
- li_iters_i  in  output_range_p  inference result
- li_yumi_o  out  1  result consumed
- resp_v_o  out  1  response valid
- resp_id_o  out  lg_req  requester id of response
- resp_iters_o  out  output_range_p  remaining-iteration estimate
- resp_ready_i  in  1  response sink ready

## Operation
- State machine: IDLE, START, SEARCH, RESP.
- **IDLE**
  - If any req_v_i is set, grant the first set bit at or after rr_ptr, wrapping modulo num_req_p.
  - Latch id_r and pc_r, go to START.
  - Otherwise stay in IDLE.
- **START**
  - start_discovery_o=1 for exactly this cycle. striding_pc_o=pc_r.
  - Clear timeout counter and conf_r, go to SEARCH.
- **SEARCH**
  - confirm_discovery_o = req_confirm_i[id_r]. When it is 1, set sticky conf_r.
  - li_yumi_o = li_v_i, combinational.
  - On li_v_i: latch li_iters_i into resp_iters_o and id_r into resp_id_o, go to RESP.
  - If !conf_r and req_v_i[id_r]==0 with no li_v_i: abort. rr_ptr = id_r+1 mod num_req_p, go to IDLE.
- **RESP**
  - resp_v_o=1. Hold the response until resp_ready_i.
  - Then rr_ptr = id_r+1 mod num_req_p, go to IDLE.
- striding_pc_o = pc_r in all states.
- Unit is never restarted while conf_r=1; start_discovery_o asserts only in START.
- Priority within the same SEARCH cycle: li_v_i > timeout > abort.
- Confirm arriving in the same cycle as li_v_i is still forwarded.
- req_v_i from non-granted requesters is ignored until IDLE.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, conf_r 0, counter 0.
  - start_discovery_o, confirm_discovery_o, li_yumi_o, resp_v_o = 0.
  - resp_id_o, resp_iters_o, striding_pc_o = 0.
- Reset mid-operation returns to IDLE next cycle with no pulse emitted. An outstanding li_v_i is left unconsumed.
- Request sampled in IDLE at cycle N → start_discovery_o at N+1 → SEARCH from N+2.
- li_v_i in SEARCH at cycle M → li_yumi_o at M (same cycle) → resp_v_o from M+1.
- Minimum request-to-response: start + unit latency + 1.
- RESP → IDLE on the cycle after a resp_ready_i handshake. A new grant can occur one cycle later.
- One IDLE cycle always separates consecutive grants.

## Configuration
- BP_BE_LOOP_SCHED_TIMEOUT_EN defined:
  - In SEARCH with conf_r=0, the counter increments each cycle.
  - On reaching timeout_cycles_p: abort as above, with rr_ptr advancing past id_r.
  - The counter freezes once conf_r=1.
- Undefined: no counter. SEARCH exits only on li_v_i or requester withdrawal.

## Test plan
- **Single request:** req_v_i=4'b0100, pc=0x8000_0040.
  - start_discovery_o pulses one cycle after, striding_pc_o=0x8000_0040.
  - li_v_i with iters=17 → li_yumi_o same cycle.
  - resp_v_o next cycle, id=2, iters=17.
- **Fairness:** req_v_i=4'b1111 held, resp_ready_i=1, unit always returns.
  - Grant order 0,1,2,3,0. Exactly one start pulse per grant.
- **Backpressure:** resp_ready_i=0 for 5 cycles after result.
  - resp_v_o/id/iters stable; no new start pulse.
  - Handshake on cycle 6 → IDLE.
- **Confirm and withdrawal:** req_confirm_i[1] pulse during SEARCH.
  - confirm_discovery_o echoes it.
  - Then req_v_i[1] drops → stays in SEARCH until li_v_i.
  - Without confirm, dropping req_v_i[1] → IDLE and requester 2 granted next.
- **Timeout (macro on):** timeout_cycles_p=8, no li_v_i, no confirm.
  - Abort after 8 SEARCH cycles, next requester granted.
  - With a confirm at SEARCH cycle 3, no abort after 8 cycles.
- **Reset mid-SEARCH:** all outputs 0 the following cycle, rr_ptr=0.

Source files
------------

// File: rtl/bp_be_loop_inference_scheduler.sv
// rtl/bp_be_loop_inference_scheduler.sv - round-robin arbiter sharing one loop-inference unit among stride requesters
// Optional abort counter enabled by defining BP_BE_LOOP_SCHED_TIMEOUT_EN.
module bp_be_loop_inference_scheduler #(
    parameter int vaddr_width_p    = 39,
    parameter int num_req_p        = 4,
    parameter int output_range_p   = 8,
    parameter int timeout_cycles_p = 1024,
    localparam int lg_req_lp       = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*vaddr_width_p-1:0] req_pc_i,
    input  logic [num_req_p-1:0]               req_confirm_i,
    output logic                               start_discovery_o,
    output logic                               confirm_discovery_o,
    output logic [vaddr_width_p-1:0]           striding_pc_o,
    input  logic                               li_v_i,
    input  logic [output_range_p-1:0]          li_iters_i,
    output logic                               li_yumi_o,
    output logic                               resp_v_o,
    output logic [lg_req_lp-1:0]               resp_id_o,
    output logic [output_range_p-1:0]          resp_iters_o,
    input  logic                               resp_ready_i
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SEARCH, S_RESP} state_e;

    state_e                      state_q, state_d;
    logic [lg_req_lp-1:0]        rr_ptr_q, rr_ptr_d;
    logic [lg_req_lp-1:0]        id_q, id_d;
    logic [vaddr_width_p-1:0]    pc_q, pc_d;
    logic                        conf_q, conf_d;
    logic [lg_req_lp-1:0]        resp_id_q, resp_id_d;
    logic [output_range_p-1:0]   resp_iters_q, resp_iters_d;

    logic                        grant_v;
    logic [lg_req_lp-1:0]        grant_id;
    logic [lg_req_lp-1:0]        cand_id;
    logic [vaddr_width_p-1:0]    grant_pc;
    logic [lg_req_lp-1:0]        next_ptr;
    logic                        timeout_hit;

    // First requesting index at or after rr_ptr, wrapping.
    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        cand_id  = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cand_id = lg_req_lp'((int'(rr_ptr_q) + i) % num_req_p);
            if (!grant_v && req_v_i[cand_id]) begin
                grant_v  = 1'b1;
                grant_id = cand_id;
            end
        end
    end

    always_comb begin
        grant_pc = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant_id == lg_req_lp'(i)) begin
                grant_pc = req_pc_i[i*vaddr_width_p +: vaddr_width_p];
            end
        end
    end

    assign next_ptr = (id_q == lg_req_lp'(num_req_p - 1)) ? '0 : id_q + lg_req_lp'(1);

`ifdef BP_BE_LOOP_SCHED_TIMEOUT_EN
    localparam int cnt_width_lp = $clog2(timeout_cycles_p + 1);

    logic [cnt_width_lp-1:0] cnt_q, cnt_d;

    // Counts unconfirmed SEARCH cycles; frozen once the search is confirmed.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_SEARCH && !conf_q) begin
            cnt_d = cnt_q + cnt_width_lp'(1);
        end
    end

    assign timeout_hit = (state_q == S_SEARCH) && !conf_q
                         && (cnt_q + cnt_width_lp'(1) == cnt_width_lp'(timeout_cycles_p));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (timeout_cycles_p == 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        pc_d         = pc_q;
        conf_d       = conf_q;
        resp_id_d    = resp_id_q;
        resp_iters_d = resp_iters_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_v) begin
                    id_d    = grant_id;
                    pc_d    = grant_pc;
                    state_d = S_START;
                end
            end
            S_START: begin
                conf_d  = 1'b0;
                state_d = S_SEARCH;
            end
            S_SEARCH: begin
                conf_d = conf_q | req_confirm_i[id_q];
                if (li_v_i) begin
                    resp_id_d    = id_q;
                    resp_iters_d = li_iters_i;
                    state_d      = S_RESP;
                end else if (timeout_hit || (!conf_q && !req_v_i[id_q])) begin
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            pc_q         <= '0;
            conf_q       <= 1'b0;
            resp_id_q    <= '0;
            resp_iters_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            pc_q         <= pc_d;
            conf_q       <= conf_d;
            resp_id_q    <= resp_id_d;
            resp_iters_q <= resp_iters_d;
        end
    end

    assign start_discovery_o   = (state_q == S_START);
    assign confirm_discovery_o = (state_q == S_SEARCH) && req_confirm_i[id_q];
    assign li_yumi_o           = (state_q == S_SEARCH) && li_v_i;
    assign resp_v_o            = (state_q == S_RESP);
    assign resp_id_o           = resp_id_q;
    assign resp_iters_o        = resp_iters_q;
    assign striding_pc_o       = pc_q;

endmodule

// File: tb/tb_bp_be_loop_inference_scheduler.sv
// tb/tb_bp_be_loop_inference_scheduler.sv - directed scoreboard bench for bp_be_loop_inference_scheduler
module tb_bp_be_loop_inference_scheduler;

    localparam int VW = 39;
    localparam int NR = 4;
    localparam int OR = 8;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] iters;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [NR-1:0]   req_v_i;
    logic [NR*VW-1:0] req_pc_i;
    logic [NR-1:0]   req_confirm_i;
    logic            start_discovery_o;
    logic            confirm_discovery_o;
    logic [VW-1:0]   striding_pc_o;
    logic            li_v_i;
    logic [OR-1:0]   li_iters_i;
    logic            li_yumi_o;
    logic            resp_v_o;
    logic [1:0]      resp_id_o;
    logic [OR-1:0]   resp_iters_o;
    logic            resp_ready_i;

    logic [VW-1:0]   pcs [NR];
    exp_t            sb [$];
    int              total = 0;
    int              bad = 0;
    int              start_cnt = 0;
    int              exp_starts = 0;

    always #5 clk = ~clk;

    assign req_pc_i = {pcs[3], pcs[2], pcs[1], pcs[0]};

    always @(posedge clk) begin
        if (start_discovery_o) start_cnt <= start_cnt + 1;
    end

    bp_be_loop_inference_scheduler #(
        .vaddr_width_p(VW),
        .num_req_p(NR),
        .output_range_p(OR),
        .timeout_cycles_p(8)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .req_v_i(req_v_i),
        .req_pc_i(req_pc_i),
        .req_confirm_i(req_confirm_i),
        .start_discovery_o(start_discovery_o),
        .confirm_discovery_o(confirm_discovery_o),
        .striding_pc_o(striding_pc_o),
        .li_v_i(li_v_i),
        .li_iters_i(li_iters_i),
        .li_yumi_o(li_yumi_o),
        .resp_v_o(resp_v_o),
        .resp_id_o(resp_id_o),
        .resp_iters_o(resp_iters_o),
        .resp_ready_i(resp_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk("resp_id", 64'(resp_id_o), 64'(e.id));
            chk("resp_iters", 64'(resp_iters_o), 64'(e.iters));
        end
    endtask

    // Entered just after the IDLE-cycle negedge in which the grant is sampled.
    task automatic run_txn(input int exp_id, input logic [7:0] iters, input int lat,
                           input int stall, input logic [3:0] req_after);
        exp_t e;
        @(negedge clk); #1;
        chk("start_pulse", 64'(start_discovery_o), 64'd1);
        chk("start_pc", 64'(striding_pc_o), 64'(pcs[exp_id]));
        exp_starts++;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk); #1;
            chk("search_start", 64'(start_discovery_o), 64'd0);
            chk("search_yumi", 64'(li_yumi_o), 64'd0);
        end
        @(negedge clk);
        li_v_i = 1'b1;
        li_iters_i = iters;
        e.id = 2'(exp_id);
        e.iters = iters;
        sb.push_back(e);
        #1;
        chk("yumi", 64'(li_yumi_o), 64'd1);
        chk("resp_early", 64'(resp_v_o), 64'd0);
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            li_v_i = 1'b0;
            resp_ready_i = (k == stall);
            #1;
            chk("resp_v", 64'(resp_v_o), 64'd1);
            chk("resp_nostart", 64'(start_discovery_o), 64'd0);
            if (k < stall) begin
                chk("hold_id", 64'(resp_id_o), 64'(exp_id));
                chk("hold_iters", 64'(resp_iters_o), 64'(iters));
            end
        end
        sb_pop_check();
        @(negedge clk);
        resp_ready_i = 1'b0;
        req_v_i = req_after;
        #1;
        chk("idle_resp_v", 64'(resp_v_o), 64'd0);
        chk("idle_start", 64'(start_discovery_o), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"}, 64'(start_discovery_o), 64'd0);
        chk({tag, "_confirm"}, 64'(confirm_discovery_o), 64'd0);
        chk({tag, "_yumi"}, 64'(li_yumi_o), 64'd0);
        chk({tag, "_resp_v"}, 64'(resp_v_o), 64'd0);
        chk({tag, "_resp_id"}, 64'(resp_id_o), 64'd0);
        chk({tag, "_resp_iters"}, 64'(resp_iters_o), 64'd0);
        chk({tag, "_pc"}, 64'(striding_pc_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pcs[0] = 39'h00_1000_0000;
        pcs[1] = 39'h40_1234_5678;
        pcs[2] = 39'h00_8000_0040;
        pcs[3] = 39'h12_0000_0abc;
        reset_i = 1'b1;
        req_v_i = '0;
        req_confirm_i = '0;
        li_v_i = 1'b0;
        li_iters_i = '0;
        resp_ready_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");

        // Single request from requester 2
        @(negedge clk);
        reset_i = 1'b0;
        req_v_i = 4'b0100;
        #1;
        chk("single_idle", 64'(start_discovery_o), 64'd0);
        run_txn(2, 8'd17, 2, 0, 4'b0000);

        // Fairness: all requesting, expect 0,1,2,3,0 from a fresh pointer
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        req_v_i = 4'b1111;
        #1;
        chk("fair_idle", 64'(start_discovery_o), 64'd0);
        for (int g = 0; g < 5; g++) begin
            run_txn(g % 4, 8'(g * 16 + 3), g % 3, 0, (g == 4) ? 4'b0000 : 4'b1111);
        end

        // Backpressure: five stalled cycles, handshake on the sixth
        @(negedge clk);
        req_v_i = 4'b0010;
        #1;
        chk("bp_idle", 64'(start_discovery_o), 64'd0);
        run_txn(1, 8'ha5, 1, 5, 4'b0000);

        // Confirm forwarded; withdrawal after confirm keeps searching
        @(negedge clk);
        req_v_i = 4'b0010;
        #1;
        chk("conf_idle", 64'(start_discovery_o), 64'd0);
        @(negedge clk); #1;
        chk("conf_start", 64'(start_discovery_o), 64'd1);
        chk("conf_pc", 64'(striding_pc_o), 64'(pcs[1]));
        exp_starts++;
        @(negedge clk);
        req_confirm_i = 4'b0010;
        #1;
        chk("conf_echo", 64'(confirm_discovery_o), 64'd1);
        @(negedge clk);
        req_confirm_i = 4'b0000;
        #1;
        chk("conf_echo_off", 64'(confirm_discovery_o), 64'd0);
        @(negedge clk);
        req_v_i = 4'b0100;
        #1;
        chk("conf_wd_start", 64'(start_discovery_o), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("conf_wd_hold", 64'(start_discovery_o), 64'd0);
            chk("conf_wd_resp", 64'(resp_v_o), 64'd0);
        end
        @(negedge clk);
        li_v_i = 1'b1;
        li_iters_i = 8'd33;
        req_confirm_i = 4'b0010;
        sb.push_back('{id: 2'd1, iters: 8'd33});
        #1;
        chk("conf_yumi", 64'(li_yumi_o), 64'd1);
        chk("conf_with_li", 64'(confirm_discovery_o), 64'd1);
        @(negedge clk);
        li_v_i = 1'b0;
        req_confirm_i = 4'b0000;
        resp_ready_i = 1'b1;
        #1;
        chk("conf_resp_v", 64'(resp_v_o), 64'd1);
        sb_pop_check();

        // Withdrawal without confirm aborts; requester 2 next
        @(negedge clk);
        resp_ready_i = 1'b0;
        req_v_i = 4'b0010;
        #1;
        chk("wd_idle", 64'(resp_v_o), 64'd0);
        @(negedge clk); #1;
        chk("wd_start", 64'(start_discovery_o), 64'd1);
        chk("wd_pc", 64'(striding_pc_o), 64'(pcs[1]));
        exp_starts++;
        @(negedge clk);
        req_v_i = 4'b0100;
        #1;
        chk("wd_search", 64'(start_discovery_o), 64'd0);
        @(negedge clk); #1;
        chk("wd_abort_idle", 64'(start_discovery_o), 64'd0);
        chk("wd_abort_resp", 64'(resp_v_o), 64'd0);
        run_txn(2, 8'd99, 0, 0, 4'b0000);

`ifdef BP_BE_LOOP_SCHED_TIMEOUT_EN
        // Timeout after 8 unconfirmed SEARCH cycles
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        req_v_i = 4'b0011;
        #1;
        @(negedge clk); #1;
        chk("to_start", 64'(start_discovery_o), 64'd1);
        exp_starts++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            chk("to_search", 64'(start_discovery_o), 64'd0);
        end
        @(negedge clk); #1;
        chk("to_idle", 64'(start_discovery_o), 64'd0);
        @(negedge clk); #1;
        chk("to_next_start", 64'(start_discovery_o), 64'd1);
        chk("to_next_pc", 64'(striding_pc_o), 64'(pcs[1]));
        exp_starts++;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            req_confirm_i = (k == 3) ? 4'b0010 : 4'b0000;
            #1;
            chk("to_conf_hold", 64'(start_discovery_o), 64'd0);
        end
        @(negedge clk);
        req_confirm_i = 4'b0000;
        li_v_i = 1'b1;
        li_iters_i = 8'h42;
        sb.push_back('{id: 2'd1, iters: 8'h42});
        #1;
        chk("to_yumi", 64'(li_yumi_o), 64'd1);
        @(negedge clk);
        li_v_i = 1'b0;
        resp_ready_i = 1'b1;
        #1;
        chk("to_resp_v", 64'(resp_v_o), 64'd1);
        sb_pop_check();
        @(negedge clk);
        resp_ready_i = 1'b0;
        req_v_i = 4'b0000;
        #1;
        chk("to_done", 64'(resp_v_o), 64'd0);
`endif

        // Reset in the middle of SEARCH
        @(negedge clk);
        req_v_i = 4'b0100;
        #1;
        @(negedge clk); #1;
        chk("rs_start", 64'(start_discovery_o), 64'd1);
        exp_starts++;
        @(negedge clk);
        req_confirm_i = 4'b0100;
        #1;
        chk("rs_confirm", 64'(confirm_discovery_o), 64'd1);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        req_v_i = 4'b0000;
        li_v_i = 1'b1;
        req_confirm_i = 4'b1111;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        li_v_i = 1'b0;
        req_confirm_i = 4'b0000;
        req_v_i = 4'b1111;
        #1;
        chk("rs_idle", 64'(start_discovery_o), 64'd0);
        run_txn(0, 8'd7, 1, 0, 4'b0000);

        repeat (2) @(negedge clk);
        chk("start_count", 64'(start_cnt), 64'(exp_starts));
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
